// File: rtl/mod_n_timer_chain_pkg.sv
// Shared definitions for the modulo-N timer chain: FSM encoding, digit width, mm:ss defaults.
// No logic of its own; the load saturation helper is pure combinational.
// No flow control involved.
package mod_n_timer_chain_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  // mm:ss defaults, packed MSB digit first: moduli 6,10,6,10 and start value 59:59
  localparam logic [15:0] DEF_MODULI   = {4'd6, 4'd10, 4'd6, 4'd10};
  localparam logic [15:0] DEF_INIT_VAL = {4'd5, 4'd9, 4'd5, 4'd9};

  // Clamp a loaded digit to the largest value the digit can legally hold
  function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] val,
                                                   input logic [DIGIT_W-1:0] maxv);
    return (val > maxv) ? maxv : val;
  endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One modulo-MOD BCD digit with up/down count, saturating parallel load and clear.
// Latency: q updates one clock after en/load/clear.
// No backpressure; en is the only advance qualifier, term reports the wrap condition.
module mod_n_digit
  import mod_n_timer_chain_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MOD  = 4'd10,
  parameter logic [DIGIT_W-1:0] INIT = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               up,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_d,
  output logic [DIGIT_W-1:0] q,
  output logic               term
);

  localparam logic [DIGIT_W-1:0] MAXV = MOD - 4'd1;

  logic [DIGIT_W-1:0] q_d, q_q;

  // Next digit value: clear beats load beats counting
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = sat_digit(load_d, MAXV);
    end else if (en) begin
      if (up) q_d = (q_q == MAXV) ? '0 : q_q + 4'd1;
      else    q_d = (q_q == '0) ? MAXV : q_q - 4'd1;
    end
  end

  // Digit register, reset to its configured start value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= INIT;
    else        q_q <= q_d;
  end

  assign q    = q_q;
  assign term = up ? (q_q == MAXV) : (q_q == '0);

endmodule

// File: rtl/mod_n_timer_chain.sv
// Cascaded modulo-N digit timer with run/stop FSM and countdown expiry.
// Latency: count updates one clock after a ce tick; ceo is combinational in the tick cycle.
// No backpressure; ce ticks outside RUN are dropped, and clear/load/stop suppress counting that cycle.
module mod_n_timer_chain
  import mod_n_timer_chain_pkg::*;
#(
  parameter int                   DIGITS       = 4,
  parameter logic [4*DIGITS-1:0]  MODULI       = DEF_MODULI,
  parameter logic [4*DIGITS-1:0]  INIT_VAL     = DEF_INIT_VAL,
  parameter bit                   STOP_AT_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                up,
  input  logic                start,
  input  logic                stop,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                clear,
  output logic [4*DIGITS-1:0] count,
  output logic                ceo,
  output logic                running,
  output logic                expired
);

  state_e              state_d, state_q;
  logic                running_d, running_q;
  logic                expired_d, expired_q;
  logic [DIGITS-1:0]   en_raw;
  logic [DIGITS-1:0]   en_dig;
  logic [DIGITS-1:0]   term;
  logic                expire_now;

  // Ripple enable chain; a tick only counts in RUN with no higher-priority control present
  always_comb begin
    en_raw    = '0;
    en_raw[0] = ce & running_q & ~clear & ~load & ~stop;
    for (int i = 1; i < DIGITS; i++) begin
      en_raw[i] = en_raw[i-1] & term[i-1];
    end
  end

  // Countdown reaching all-zero freezes the digits instead of wrapping
  assign expire_now = STOP_AT_ZERO && !up && (count == '0) && en_raw[0];
  assign en_dig     = en_raw & {DIGITS{~expire_now}};
  assign ceo        = en_raw[DIGITS-1] & term[DIGITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    mod_n_digit #(
      .MOD  (MODULI[DIGIT_W*i +: DIGIT_W]),
      .INIT (INIT_VAL[DIGIT_W*i +: DIGIT_W])
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .en     (en_dig[i]),
      .up     (up),
      .clear  (clear),
      .load   (load),
      .load_d (load_val[DIGIT_W*i +: DIGIT_W]),
      .q      (count[DIGIT_W*i +: DIGIT_W]),
      .term   (term[i])
    );
  end

  // Next FSM state: clear/load force IDLE, stop wins over start, expiry only from RUN
  always_comb begin
    state_d = state_q;
    if (clear || load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (!stop && start) state_d = ST_RUN;
        ST_RUN:     if (stop) state_d = ST_IDLE;
                    else if (expire_now) state_d = ST_EXPIRED;
        ST_EXPIRED: state_d = ST_EXPIRED;
        default:    state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  // FSM state and its registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_mod_n_timer_chain.sv
// Scoreboarded directed test of the default mm:ss timer chain.
module tb_mod_n_timer_chain;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ce = 1'b0, up = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0, clear = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        ceo, running, expired;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [15:0] cnt;
    logic        run;
    logic        expd;
  } st_t;

  typedef struct {
    int   due;
    logic v;
  } ceo_t;

  st_t  st_q[$];
  ceo_t ceo_q[$];

  mod_n_timer_chain dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .up       (up),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .clear    (clear),
    .count    (count),
    .ceo      (ceo),
    .running  (running),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at each falling edge retire every expectation due this cycle
  always @(negedge clk) begin
    while (ceo_q.size() > 0 && ceo_q[0].due <= cyc) begin
      ceo_t c;
      c = ceo_q.pop_front();
      n_chk++;
      if (c.due != cyc || ceo !== c.v) begin
        n_fail++;
        $display("FAIL ceo cyc=%0d due=%0d actual=%b required=%b", cyc, c.due, ceo, c.v);
      end
    end
    while (st_q.size() > 0 && st_q[0].due <= cyc) begin
      st_t s;
      s = st_q.pop_front();
      n_chk++;
      if (s.due != cyc || count !== s.cnt) begin
        n_fail++;
        $display("FAIL count cyc=%0d due=%0d actual=%h required=%h", cyc, s.due, count, s.cnt);
      end
      n_chk++;
      if (running !== s.run) begin
        n_fail++;
        $display("FAIL running cyc=%0d actual=%b required=%b", cyc, running, s.run);
      end
      n_chk++;
      if (expired !== s.expd) begin
        n_fail++;
        $display("FAIL expired cyc=%0d actual=%b required=%b", cyc, expired, s.expd);
      end
    end
  end

  // Apply one cycle of inputs; ceo is expected this cycle, state after the next edge
  task automatic step(input logic i_ce, input logic i_start, input logic i_stop,
                      input logic i_load, input logic i_clear, input logic i_up,
                      input logic [15:0] lv, input bit chk,
                      input logic [15:0] e_cnt, input logic e_run, input logic e_exp,
                      input logic e_ceo);
    @(posedge clk);
    #1;
    ce = i_ce; start = i_start; stop = i_stop; load = i_load; clear = i_clear;
    up = i_up; load_val = lv;
    ceo_q.push_back('{due: cyc, v: e_ceo});
    if (chk) st_q.push_back('{due: cyc + 1, cnt: e_cnt, run: e_run, expd: e_exp});
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    ceo_q.push_back('{due: cyc, v: 1'b0});
    st_q.push_back('{due: cyc, cnt: 16'h5959, run: 1'b0, expd: 1'b0});
    @(negedge clk);
    #1 reset = 1'b1;

    // ce in IDLE is ignored
    step(1, 0, 0, 0, 0, 0, 16'h0, 1, 16'h5959, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 16'h0, 1, 16'h5959, 1, 0, 0);
    // Count down from 59:59
    for (int i = 1; i <= 60; i++) begin
      logic [15:0] e;
      e = (i == 1) ? 16'h5958 : (i == 10) ? 16'h5949 : 16'h5859;
      step(1, 0, 0, 0, 0, 0, 16'h0, (i == 1 || i == 10 || i == 60), e, 1, 0, 0);
    end
    // stop beats a coincident tick
    step(1, 0, 1, 0, 0, 0, 16'h0, 1, 16'h5859, 0, 0, 0);

    // Down expiry
    step(0, 0, 0, 1, 0, 0, 16'h0002, 1, 16'h0002, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 16'h0,    1, 16'h0002, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 16'h0,    1, 16'h0001, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 16'h0,    1, 16'h0000, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 16'h0,    1, 16'h0000, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 16'h0, 1, 16'h0000, 0, 1, 0);
    // start ignored while expired
    step(0, 1, 0, 0, 0, 0, 16'h0, 1, 16'h0000, 0, 1, 0);

    // Up wrap through 59:59
    step(0, 0, 0, 1, 0, 1, 16'h5958, 1, 16'h5958, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 16'h0,    1, 16'h5958, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 16'h0,    1, 16'h5959, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 16'h0,    1, 16'h0000, 1, 0, 1);
    step(0, 0, 1, 0, 0, 1, 16'h0,    1, 16'h0000, 0, 0, 0);

    // Load saturation, clear over load, stop over start
    step(0, 0, 0, 1, 0, 0, 16'hF9A9, 1, 16'h5959, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 16'h1234, 1, 16'h0000, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 16'h0,    1, 16'h0000, 0, 0, 0);

    // Reset mid-run during a tick that would otherwise expire and pulse ceo
    step(0, 1, 0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    ce = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; clear = 1'b0; up = 1'b0;
    #2 reset = 1'b0;
    ceo_q.push_back('{due: cyc, v: 1'b0});
    st_q.push_back('{due: cyc, cnt: 16'h5959, run: 1'b0, expd: 1'b0});
    @(negedge clk);
    #1;
    reset = 1'b1;
    ce = 1'b0;
    // Needs start again after reset
    step(1, 0, 0, 0, 0, 0, 16'h0, 1, 16'h5959, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 16'h0, 1, 16'h5959, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 16'h0, 1, 16'h5958, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 16'h0, 1, 16'h5958, 1, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (st_q.size() != 0 || ceo_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d/%0d left required=0/0", st_q.size(), ceo_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
